// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage ARM-subset core.
// Keeps shadow copies of the destination tags in flight in EX/MEM/WB and
// derives operand forwarding selects, the load-use bubble, the taken-branch
// flush and the whole-pipeline freeze while data memory is busy.
module hazard_ctrl #(
  parameter int NREG = 16,
  parameter int TW   = $clog2(NREG),
  parameter logic [TW-1:0] PC_TAG = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [TW-1:0] id_rn,
  input  logic [TW-1:0] id_rm,
  input  logic [TW-1:0] id_rd,
  input  logic          id_use_rn,
  input  logic          id_use_rm,
  input  logic          id_use_rd,
  input  logic [TW-1:0] id_dest,
  input  logic          id_rf_enable,
  input  logic          id_load_instr,
  input  logic          id_branch_taken,
  input  logic          mem_busy,
  output logic          cu_mux_s,
  output logic          pc_le,
  output logic          ifid_le,
  output logic          ifid_flush,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic [1:0]    fwd_c,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FREEZE   = 2'b10
  } state_t;

  typedef struct packed {
    logic          wr;
    logic          load;
    logic [TW-1:0] dest;
  } slot_t;

  state_t state_q, state_d;
  slot_t  ex_q, mem_q, wb_q;
  logic   lu;
  logic   freeze;

  // A slot supplies tag t only if it really writes t and t is not the PC.
  function automatic logic hit(slot_t s, logic [TW-1:0] t, logic use_t);
    return use_t & s.wr & (s.dest == t) & (t != PC_TAG);
  endfunction

  // Youngest producer wins: EX, then MEM, then WB, else register file.
  function automatic logic [1:0] fwd_sel(slot_t ex, slot_t mem, slot_t wb,
                                         logic [TW-1:0] t, logic use_t);
    if (hit(ex, t, use_t))       return 2'b01;
    else if (hit(mem, t, use_t)) return 2'b10;
    else if (hit(wb, t, use_t))  return 2'b11;
    else                         return 2'b00;
  endfunction

  // Hazard detection, stall/freeze outputs, forwarding and next state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    pc_le    = 1'b1;
    ifid_le  = 1'b1;
    cu_mux_s = 1'b0;
    fwd_a    = fwd_sel(ex_q, mem_q, wb_q, id_rn, id_use_rn);
    fwd_b    = fwd_sel(ex_q, mem_q, wb_q, id_rm, id_use_rm);
    fwd_c    = fwd_sel(ex_q, mem_q, wb_q, id_rd, id_use_rd);

    lu     = ex_q.load & (hit(ex_q, id_rn, id_use_rn) |
                          hit(ex_q, id_rm, id_use_rm) |
                          hit(ex_q, id_rd, id_use_rd));
    freeze = mem_busy | (state_q == FREEZE);

    if (mem_busy) begin
      state_d = FREEZE;
    end else begin
      unique case (state_q)
        RUN:      state_d = lu ? LU_STALL : RUN;
        LU_STALL: state_d = RUN;
        FREEZE:   state_d = RUN;
        default:  state_d = RUN;
      endcase
    end

    if (freeze) begin
      pc_le   = 1'b0;
      ifid_le = 1'b0;
    end else if (state_q == RUN && lu) begin
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      cu_mux_s = 1'b1;
    end

    if (!rst_n) begin
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      cu_mux_s = 1'b1;
      fwd_a    = 2'b00;
      fwd_b    = 2'b00;
      fwd_c    = 2'b00;
    end

    // A branch held behind a stall or freeze flushes only once it advances.
    ifid_flush = id_branch_taken & pc_le & ~cu_mux_s;
  end

  assign state_o = state_q;

  // State register and shadow-slot shift; slots hold while frozen.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so the shift
    // EX->MEM->WB reads the pre-edge values of every slot.
    if (!rst_n) begin
      state_q <= RUN;
      // NOTE: slots are reset because a stale tag would raise phantom
      // forwards or stalls after reset.
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (!freeze) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= '{wr:   id_rf_enable  & ~cu_mux_s,
                   load: id_load_instr & ~cu_mux_s,
                   dest: id_dest};
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus for hazard_ctrl, checked
// each cycle against a queue-based model of the instructions in flight.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_rn, id_rm, id_rd, id_dest;
  logic       id_use_rn, id_use_rm, id_use_rd;
  logic       id_rf_enable, id_load_instr, id_branch_taken, mem_busy;
  logic       cu_mux_s, pc_le, ifid_le, ifid_flush;
  logic [1:0] fwd_a, fwd_b, fwd_c, state_o;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_dest(id_dest), .id_rf_enable(id_rf_enable),
    .id_load_instr(id_load_instr), .id_branch_taken(id_branch_taken),
    .mem_busy(mem_busy), .cu_mux_s(cu_mux_s), .pc_le(pc_le),
    .ifid_le(ifid_le), .ifid_flush(ifid_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .state_o(state_o)
  );

  // Model: instructions in flight, youngest (EX) at index 0.
  typedef struct {
    bit       wr;
    bit       load;
    bit [3:0] dest;
  } slot_t;

  slot_t pipe[$];
  bit    busy_last;    // mem_busy was high in the previous cycle
  bit    bubble_last;  // a load-use bubble was inserted in the previous cycle
  bit    model_valid;  // a reset edge has been seen
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(slot_t s, bit [3:0] t, bit u);
    return u && s.wr && s.dest == t && t != 4'hF;
  endfunction

  function automatic bit [1:0] model_fwd(bit [3:0] t, bit u);
    for (int i = 0; i < 3; i++)
      if (hit(pipe[i], t, u)) return 2'(i + 1);
    return 2'b00;
  endfunction

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back('{0, 0, 4'h0});
    busy_last   = 0;
    bubble_last = 0;
  endfunction

  // One clock: compare all outputs to the model, then advance both.
  task automatic cycle();
    bit       frozen, in_run, lu, stall, adv;
    bit [1:0] st_exp;
    #2;
    st_exp = busy_last ? 2'd2 : (bubble_last ? 2'd1 : 2'd0);
    frozen = mem_busy || busy_last;
    in_run = (st_exp == 2'd0);
    lu     = pipe[0].load && (hit(pipe[0], id_rn, id_use_rn) ||
                              hit(pipe[0], id_rm, id_use_rm) ||
                              hit(pipe[0], id_rd, id_use_rd));
    stall  = !frozen && in_run && lu;
    adv    = !frozen && !stall;
    if (!rst_n) begin
      check("rst_pc_le", pc_le, 0);
      check("rst_ifid_le", ifid_le, 0);
      check("rst_cu_mux_s", cu_mux_s, 1);
      check("rst_flush", ifid_flush, 0);
      check("rst_fwd_a", fwd_a, 0);
      check("rst_fwd_b", fwd_b, 0);
      check("rst_fwd_c", fwd_c, 0);
      if (model_valid) check("rst_state", state_o, st_exp);
    end else begin
      check("state", state_o, st_exp);
      check("pc_le", pc_le, adv);
      check("ifid_le", ifid_le, adv);
      check("cu_mux_s", cu_mux_s, stall);
      check("flush", ifid_flush, id_branch_taken && adv);
      check("fwd_a", fwd_a, model_fwd(id_rn, id_use_rn));
      check("fwd_b", fwd_b, model_fwd(id_rm, id_use_rm));
      check("fwd_c", fwd_c, model_fwd(id_rd, id_use_rd));
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      model_valid = 1;
    end else begin
      if (!frozen) begin
        pipe.push_front('{id_rf_enable && !stall, id_load_instr && !stall,
                          id_dest});
        void'(pipe.pop_back());
      end
      busy_last   = mem_busy;
      bubble_last = stall;
    end
    #1;
  endtask

  task automatic id(input bit [3:0] rn, input bit [3:0] rm, input bit [3:0] rd,
                    input bit urn, input bit urm, input bit urd,
                    input bit [3:0] dest, input bit rf, input bit ld);
    id_rn = rn; id_rm = rm; id_rd = rd;
    id_use_rn = urn; id_use_rm = urm; id_use_rd = urd;
    id_dest = dest; id_rf_enable = rf; id_load_instr = ld;
  endtask

  task automatic nops(input int n);
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  function automatic bit [3:0] rtag();
    if ($urandom_range(0, 7) == 0) return 4'hF;
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    model_reset();
    model_valid = 0;
    rst_n = 0; mem_busy = 0; id_branch_taken = 0;

    // Reset with a hazard-looking instruction in ID.
    id(1, 1, 1, 1, 1, 1, 1, 1, 1);
    #1 check("reset_cu", cu_mux_s, 1);
    cycle();
    cycle();
    rst_n = 1;
    nops(0);
    #1 check("release_pc", pc_le, 1);
    check("release_state", state_o, 0);
    cycle();

    // ADD R1 followed by SUB using R1 after 0..3 independent instructions.
    for (int gap = 0; gap < 4; gap++) begin
      id(0, 0, 0, 0, 0, 0, 1, 1, 0);
      cycle();
      nops(gap);
      id(1, 0, 0, 1, 0, 0, 6, 1, 0);
      #1 check("fwd_a_gap", fwd_a, (gap < 3) ? 2'(gap + 1) : 2'b00);
      cycle();
      nops(3);
    end

    // LDR R2 then ADD using R2 as Rm: one bubble, then forward from MEM.
    id(0, 0, 0, 0, 0, 0, 2, 1, 1);
    cycle();
    id(0, 2, 0, 0, 1, 0, 3, 1, 0);
    #1 check("lu_cu", cu_mux_s, 1);
    check("lu_pc", pc_le, 0);
    check("lu_ifid", ifid_le, 0);
    cycle();
    #1 check("lu_state", state_o, 1);
    check("lu_fwd_b", fwd_b, 2'b10);
    check("lu_nostall", cu_mux_s, 0);
    cycle();
    nops(3);

    // Load writing R15 never forwards or stalls.
    id(0, 0, 0, 0, 0, 0, 15, 1, 1);
    cycle();
    id(15, 15, 15, 1, 1, 1, 4, 1, 0);
    #1 check("r15_cu", cu_mux_s, 0);
    check("r15_fwd_a", fwd_a, 0);
    cycle();
    nops(3);

    // Slot with wr=0 but a matching tag.
    id(0, 0, 0, 0, 0, 0, 3, 0, 1);
    cycle();
    id(3, 3, 3, 1, 1, 1, 4, 1, 0);
    #1 check("nowr_cu", cu_mux_s, 0);
    check("nowr_fwd_c", fwd_c, 0);
    cycle();
    nops(3);

    // mem_busy for 3 cycles during a load-use condition.
    id(0, 0, 0, 0, 0, 0, 4, 1, 1);
    cycle();
    id(4, 0, 0, 1, 0, 0, 5, 1, 0);
    mem_busy = 1;
    #1 check("busy_cu", cu_mux_s, 0);
    check("busy_pc", pc_le, 0);
    repeat (3) cycle();
    mem_busy = 0;
    #1 check("freeze_state", state_o, 2);
    check("freeze_fwd_a", fwd_a, 2'b01);
    cycle();
    #1 check("after_freeze_cu", cu_mux_s, 1);
    cycle();
    #1 check("after_bubble_state", state_o, 1);
    cycle();
    nops(3);

    // Taken branch: immediate flush in RUN, deferred behind a load-use stall.
    id_branch_taken = 1;
    nops(0);
    #1 check("br_flush", ifid_flush, 1);
    cycle();
    id_branch_taken = 0;
    id(0, 0, 0, 0, 0, 0, 5, 1, 1);
    cycle();
    id(5, 0, 0, 1, 0, 0, 0, 0, 0);
    id_branch_taken = 1;
    #1 check("br_lu_flush", ifid_flush, 0);
    cycle();
    #1 check("br_late_flush", ifid_flush, 1);
    cycle();
    id_branch_taken = 0;
    nops(3);

    // Reset in the middle of a load-use stall discards everything.
    id(0, 0, 0, 0, 0, 0, 6, 1, 1);
    cycle();
    id(6, 6, 0, 1, 1, 0, 7, 1, 0);
    cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    #1 check("rst_mid_state", state_o, 0);
    check("rst_mid_cu", cu_mux_s, 0);
    cycle();

    // Back-to-back dependent loads: one bubble per dependent pair.
    id(0, 0, 0, 0, 0, 0, 7, 1, 1);
    cycle();
    id(7, 0, 0, 1, 0, 0, 8, 1, 1);
    repeat (2) cycle();
    id(0, 8, 0, 0, 1, 0, 9, 1, 0);
    repeat (2) cycle();
    nops(3);

    // Random traffic over a small tag set so hazards are frequent.
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      mem_busy = ($urandom_range(0, 6) == 0);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      id(rtag(), rtag(), rtag(), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rtag(),
         1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
